// File: rtl/sub16_serial.sv
// rtl/sub16_serial.sv - bit-serial 16-bit subtractor, LSB first, one bit per clock
// Optional SUB16_SERIAL_SAT_EN: clamp diff to 0 when the final borrow is set.
module sub16_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             borrow_q, borrow_d;

   logic             a_bit, b_bit, d_bit, br_next;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      a_bit    = a_sh_q[0];
      b_bit    = b_sh_q[0];
      d_bit    = a_bit ^ b_bit ^ br_q;
      br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
      res_next = {d_bit, res_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      diff_d   = diff_q;
      br_d     = br_q;
      borrow_d = borrow_q;
      ready    = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_d = RUN;
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = 1'b0;
               cnt_d   = 4'd0;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_next;
            res_d  = res_next;
            cnt_d  = cnt_q + 4'd1;
            // Results are published only once all 16 bits are in.
            if (cnt_q == 4'd15) begin
               state_d  = DONE;
               borrow_d = br_next;
`ifdef SUB16_SERIAL_SAT_EN
               diff_d   = br_next ? '0 : res_next;
`else
               diff_d   = res_next;
`endif
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         br_q     <= br_d;
         borrow_q <= borrow_d;
      end
   end

   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_sub16_serial.sv
// tb/tb_sub16_serial.sv - directed self-checking bench for sub16_serial
// Expected diffs switch with SUB16_SERIAL_SAT_EN.
module tb_sub16_serial;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        ready, done, borrow;
   logic [15:0] diff;

   int errors = 0;
   int checks = 0;

`ifdef SUB16_SERIAL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   sub16_serial #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .done  (done),
      .diff  (diff),
      .borrow(borrow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Accept at the first edge, then expect done exactly 16 edges later.
   task automatic run_op(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                         input logic [15:0] d_plain, input logic [15:0] d_sat, input logic bo);
      int early;
      a = ai;
      b = bi;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = ~ai;
      b = ~bi;
      chk({tag, ".ready_run"}, {15'd0, ready}, 16'd0);
      early = 0;
      repeat (15) begin
         tick();
         if (done !== 1'b0) early++;
      end
      chk({tag, ".no_early_done"}, early[15:0], 16'd0);
      tick();
      chk({tag, ".done"}, {15'd0, done}, 16'd1);
      chk({tag, ".diff"}, diff, SAT ? d_sat : d_plain);
      chk({tag, ".borrow"}, {15'd0, borrow}, {15'd0, bo});
      tick();
      chk({tag, ".done_one_cycle"}, {15'd0, done}, 16'd0);
      chk({tag, ".ready_idle"}, {15'd0, ready}, 16'd1);
      chk({tag, ".diff_hold"}, diff, SAT ? d_sat : d_plain);
   endtask

   initial begin
      int cnt;

      // Reset, with start asserted on the reset edge: must be ignored.
      reset = 1'b1;
      start = 1'b1;
      a = 16'h0005;
      b = 16'h0003;
      tick();
      tick();
      start = 1'b0;
      chk("rst.ready", {15'd0, ready}, 16'd1);
      chk("rst.done", {15'd0, done}, 16'd0);
      chk("rst.diff", diff, 16'h0000);
      chk("rst.borrow", {15'd0, borrow}, 16'd0);
      reset = 1'b0;

      run_op("sub_5_3", 16'h0005, 16'h0003, 16'h0002, 16'h0002, 1'b0);
      run_op("sub_3_5", 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1);
      run_op("sub_0_1", 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b1);
      run_op("sub_8000", 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0);
      run_op("sub_b0", 16'hABCD, 16'h0000, 16'hABCD, 16'hABCD, 1'b0);
      run_op("sub_eq", 16'h5A5A, 16'h5A5A, 16'h0000, 16'h0000, 1'b0);

      // start pulse during RUN is ignored.
      a = 16'h1234;
      b = 16'h0034;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      a = 16'hFFFF;
      b = 16'h0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      repeat (10) begin
         tick();
         if (ready !== 1'b0 || done !== 1'b0) cnt++;
      end
      chk("ign.ready_low", cnt[15:0], 16'd0);
      tick();
      chk("ign.done", {15'd0, done}, 16'd1);
      chk("ign.diff", diff, 16'h1200);
      chk("ign.borrow", {15'd0, borrow}, 16'd0);
      cnt = 0;
      repeat (20) begin
         tick();
         if (done !== 1'b0) cnt++;
      end
      chk("ign.single_done", cnt[15:0], 16'd0);

      // Reset mid-RUN aborts with no done pulse.
      a = 16'h00F0;
      b = 16'h000F;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort.ready", {15'd0, ready}, 16'd1);
      chk("abort.diff", diff, 16'h0000);
      chk("abort.borrow", {15'd0, borrow}, 16'd0);
      cnt = 0;
      repeat (20) begin
         tick();
         if (done !== 1'b0) cnt++;
      end
      chk("abort.no_done", cnt[15:0], 16'd0);

      run_op("after_abort", 16'h00F0, 16'h000F, 16'h00E1, 16'h00E1, 1'b1 & 1'b0);

      // Back-to-back with start held high: one accept every 18 edges.
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         logic [15:0] av, bv, ev;
         logic        eb;
         case (i)
            0: begin av = 16'h0100; bv = 16'h0001; ev = 16'h00FF; eb = 1'b0; end
            1: begin av = 16'h0001; bv = 16'h0002; ev = SAT ? 16'h0000 : 16'hFFFF; eb = 1'b1; end
            default: begin av = 16'hFFFF; bv = 16'hFFFE; ev = 16'h0001; eb = 1'b0; end
         endcase
         a = av;
         b = bv;
         tick();
         a = 16'h0000;
         b = 16'hFFFF;
         cnt = 0;
         repeat (15) begin
            tick();
            if (done !== 1'b0) cnt++;
         end
         chk($sformatf("b2b%0d.no_early", i), cnt[15:0], 16'd0);
         tick();
         chk($sformatf("b2b%0d.done", i), {15'd0, done}, 16'd1);
         chk($sformatf("b2b%0d.diff", i), diff, ev);
         chk($sformatf("b2b%0d.borrow", i), {15'd0, borrow}, {15'd0, eb});
         tick();
         chk($sformatf("b2b%0d.ready", i), {15'd0, ready}, 16'd1);
      end
      start = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sub16_serial.md
SUB16_SERIAL -- requirements
Module: sub16_serial

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; only 16 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only while ready=1.
REQ-005 Port: a  input  16  minuend; captured on the accepted start edge.
REQ-006 Port: b  input  16  subtrahend; captured on the accepted start edge.
REQ-007 Port: ready  output  1  high only in IDLE; block can accept start.
REQ-008 Port: done  output  1  single-cycle pulse; diff and borrow are valid.
REQ-009 Port: diff  output  16  result a-b modulo 2^16 (see REQ-030).
REQ-010 Port: borrow  output  1  high when a<b (unsigned); this is the final borrow out of bit 15.

Function
REQ-011 Operation: bit-serial ripple subtraction, LSB first, one bit per clock, using a 1-bit borrow register.
REQ-012 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-013 IDLE -> RUN on any edge with start=1; on that edge:
- a and b are latched into shift registers;
- borrow register is cleared;
- bit counter is cleared to 0.
REQ-014 RUN, each edge, processing bit i = counter:
- d_i = a_i XOR b_i XOR br;
- br_next = (~a_i & b_i) | (~(a_i XOR b_i) & br);
- d_i is shifted into result MSB-side;
- counter increments.
REQ-015 RUN -> DONE on the edge that processes bit 15 (counter=15); counter is 4 bits and does not wrap into a further RUN cycle.
REQ-016 DONE -> IDLE unconditionally on the next edge.
REQ-017 done=1 only while in DONE, giving exactly one cycle; ready=0 in RUN and DONE.
REQ-018 Latency: start accepted at edge k gives done high in the cycle after edge k+16; the next start can be accepted at edge k+18.
REQ-019 start while in RUN or DONE is ignored; a and b changes after capture do not affect the result.
REQ-020 diff and borrow update only on the RUN->DONE edge.
REQ-021 diff and borrow hold their values in DONE and IDLE until the next operation completes.
REQ-022 diff and borrow are not required to show valid intermediate values during RUN.
REQ-023 a=b gives diff=0, borrow=0; b=0 gives diff=a, borrow=0.

Reset
REQ-024 reset=1 at an edge forces:
- state=IDLE, ready=1, done=0;
- diff=0, borrow=0;
- counter, borrow register and shift registers = 0.
REQ-025 reset has priority over start and aborts an in-flight RUN or DONE; the aborted operation produces no done pulse.
REQ-026 start sampled on the same edge as reset is ignored.
REQ-027 First start can be accepted on the first edge with reset=0.

Configuration
REQ-028 Macro SUB16_SERIAL_SAT_EN selects unsigned saturating mode.
REQ-029 Without SUB16_SERIAL_SAT_EN: diff = (a-b) mod 2^16.
REQ-030 With SUB16_SERIAL_SAT_EN: if the final borrow is 1, diff=0x0000 at the RUN->DONE edge; otherwise diff=a-b. borrow reports the true borrow in both modes.
REQ-031 Timing, handshake and reset behaviour are identical in both builds.

Verification
REQ-032 a=0x0005, b=0x0003, start 1 cycle -> done at edge+17 cycle, diff=0x0002, borrow=0.
REQ-033 a=0x0003, b=0x0005 -> borrow=1; diff=0xFFFE without the macro; diff=0x0000 with SUB16_SERIAL_SAT_EN.
REQ-034 Edge values:
- a=0x0000, b=0x0001 -> diff=0xFFFF (0x0000 with macro), borrow=1;
- a=0x8000, b=0x8000 -> diff=0x0000, borrow=0.
REQ-035 Start a=0x1234, b=0x0034, then pulse start with a=0xFFFF, b=0x0000 at RUN cycle 5 -> single done, diff=0x1200, borrow=0, ready low until after DONE.
REQ-036 Start a=0x00F0, b=0x000F; assert reset at RUN cycle 8 -> no done pulse, diff=0, borrow=0, ready=1 next cycle.
REQ-037 Then start a=0x00F0, b=0x000F -> diff=0x00E1, borrow=0 after 17 cycles.
REQ-038 Back-to-back: hold start=1 continuously -> done pulses every 18 cycles, each with the correct result for operands present at each accepting edge.
